game_timer_ctrl: RTL
====================

Name: game_timer_ctrl

Overview:
Control stage directly upstream of the countdown digit chain. It issues the one-cycle reconfig pulse that preloads the digits and a prescaled one-tick-per-second borrow pulse into the least-significant digit. It consumes the chain's exhausted flag, which is NoBorrowDn of the least-significant digit, and raises a sticky timeout that ends the game. It also keeps an elapsed-seconds count for scoring.

Parameters:
TICK_CYCLES, 50000000, clk cycles per tick (one second at 50 MHz); legal range 2 to 2^CNT_W.
CNT_W, 26, prescaler width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  start/restart request, level; only its rising edge acts
hold  input  1  pause; 1 freezes prescaler while RUN
abort  input  1  game finished by player; ends run without timeout
timer_zero  input  1  NoBorrowDn from least-significant digit, level
reconfig  output  1  one-cycle preload pulse to every digit
tick  output  1  one-cycle BorrowDn pulse to least-significant digit
timeout  output  1  sticky: countdown exhausted
running  output  1  1 only in RUN
state  output  2  IDLE=00, LOAD=01, RUN=10, DONE=11
elapsed  output  8  ticks issued since last LOAD, saturating

Behaviour:
- Reset (rst=0, asynchronous, overrides everything): state=IDLE, prescaler=0, start_q=0.
- Reset values of outputs: reconfig=0, tick=0, timeout=0, running=0, elapsed=0.
- All outputs are registered; there are no combinational paths from input to output.
- Edge detect: start_q is a registered copy of start; start_edge = start & ~start_q. A start held high never retriggers.
- IDLE: start_edge -> LOAD on the next edge.
- Entering LOAD (same edge): reconfig<=1, prescaler<=0, elapsed<=0, timeout<=0.
- LOAD lasts exactly one cycle, then goes to RUN unconditionally; reconfig<=0 on that edge. Inputs are ignored while in LOAD.
- RUN, evaluated in priority order each cycle:
  1. timer_zero=1 -> DONE, timeout<=1, no tick this cycle.
  2. abort=1 -> DONE, timeout stays 0.
  3. start_edge -> LOAD (restart, same actions as entering LOAD).
  4. hold=1 -> prescaler frozen, tick<=0.
  5. Otherwise the prescaler increments. When prescaler==TICK_CYCLES-1: prescaler<=0, tick<=1 for one cycle, and elapsed<=elapsed+1, saturating at 255.
- The first tick after LOAD is TICK_CYCLES cycles after the first RUN cycle.
- hold does not reset the prescaler; a partial count resumes when hold drops.
- tick is never asserted in two consecutive cycles, and never outside RUN.
- DONE: timeout holds its value, running=0, tick=0, elapsed frozen. start_edge -> LOAD. timer_zero and abort are ignored.
- running<=1 on the edge that enters RUN and <=0 on the edge that leaves it.
- timer_zero is a level input: it stays high until the digits are reconfigured. Because it is sampled only in RUN, a stale high cannot cause a false timeout after LOAD; the digits clear NoBorrowDn on reconfig, which is asserted the cycle before RUN.
- Reset asserted mid-run returns immediately to IDLE with all outputs at their reset values. No reconfig is issued until the next start edge.

Test Plan:
All scenarios use TICK_CYCLES=4.
1. Reset, then raise start and hold it high -> state 00->01->10 and reconfig=1 for exactly one cycle. The first tick arrives 4 cycles after entering RUN, then one every 4 cycles. start staying high never re-enters LOAD.
2. In RUN, assert hold for 10 cycles midway through a prescaler count -> no ticks during hold. The next tick arrives after the remaining count, with no restart of the prescaler. elapsed is unchanged during hold.
3. In RUN, assert timer_zero in the same cycle the prescaler reaches 3 -> state=DONE, timeout=1, running=0, no tick pulse, elapsed not incremented.
4. In RUN, assert abort and timer_zero together -> DONE with timeout=1. Repeat with abort alone -> DONE with timeout=0.
5. From DONE with timeout=1, pulse start -> LOAD: timeout cleared, elapsed=0, reconfig pulse, then RUN. A timer_zero held high through the LOAD cycle does not re-trigger before the digits reload.
6. Run 300 ticks with no timer_zero -> elapsed saturates at 255. Assert rst mid-count -> all outputs 0 and state=IDLE immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// ---------------------------------------------------------------------------
// game_timer_ctrl
//
// Control stage that sits directly in front of the countdown digit chain.
//   * issues a one-cycle reconfig pulse that preloads every digit
//   * issues a prescaled one-per-second tick (BorrowDn) into the LS digit
//   * watches the chain's exhausted flag (NoBorrowDn of the LS digit) and
//     raises a sticky timeout
//   * counts elapsed seconds (saturating) for scoring
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   start       start/restart request (level, rising edge acts)
//   hold        pause: freezes the prescaler while running
//   abort       player finished: ends the run without timeout
//   timer_zero  NoBorrowDn from the least-significant digit (level)
//   reconfig    one-cycle preload pulse to every digit
//   tick        one-cycle BorrowDn pulse to the least-significant digit
//   timeout     sticky: countdown exhausted
//   running     1 only while in RUN
//   state       IDLE=00, LOAD=01, RUN=10, DONE=11
//   elapsed     ticks issued since the last LOAD, saturating at 255
// ---------------------------------------------------------------------------
module game_timer_ctrl #(
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       abort,
  input  logic       timer_zero,
  output logic       reconfig,
  output logic       tick,
  output logic       timeout,
  output logic       running,
  output logic [1:0] state,
  output logic [7:0] elapsed
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] prescaler;
  logic             start_q;
  logic             start_edge;

  // A start held high only acts once: the registered copy masks it.
  assign start_edge = start & ~start_q;
  assign state      = state_q;

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values sampled on the same clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state is plain flops (no memory arrays), so everything is
      // cleared asynchronously and outputs drop without waiting for clk.
      state_q   <= IDLE;
      prescaler <= '0;
      start_q   <= 1'b0;
      reconfig  <= 1'b0;
      tick      <= 1'b0;
      timeout   <= 1'b0;
      running   <= 1'b0;
      elapsed   <= '0;
    end else begin
      start_q  <= start;
      // Pulses default low; the branches below raise them for one cycle.
      reconfig <= 1'b0;
      tick     <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q   <= LOAD;
            reconfig  <= 1'b1;
            prescaler <= '0;
            elapsed   <= '0;
            timeout   <= 1'b0;
          end
        end

        // Single preload cycle; inputs are deliberately not looked at so a
        // stale timer_zero from the previous game cannot end this one.
        LOAD: begin
          state_q <= RUN;
          running <= 1'b1;
        end

        RUN: begin
          if (timer_zero) begin
            state_q <= DONE;
            timeout <= 1'b1;
            running <= 1'b0;
          end else if (abort) begin
            state_q <= DONE;
            running <= 1'b0;
          end else if (start_edge) begin
            state_q   <= LOAD;
            reconfig  <= 1'b1;
            prescaler <= '0;
            elapsed   <= '0;
            timeout   <= 1'b0;
            running   <= 1'b0;
          end else if (!hold) begin
            // hold leaves the partial count intact so it resumes later.
            if (prescaler == TICK_LAST) begin
              prescaler <= '0;
              tick      <= 1'b1;
              if (elapsed != 8'hFF) elapsed <= elapsed + 8'd1;
            end else begin
              prescaler <= prescaler + CNT_W'(1);
            end
          end
        end

        DONE: begin
          if (start_edge) begin
            state_q   <= LOAD;
            reconfig  <= 1'b1;
            prescaler <= '0;
            elapsed   <= '0;
            timeout   <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
